// File: rtl/scalar_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : scalar_operand_stage_if
// Purpose  : Bundles the ID-side instruction fields, register-file read data,
//            forwarding sources, stall/flush controls and the EX pipeline
//            register outputs of the scalar operand stage.
// Modports : master - the surrounding pipeline (drives ID/forward/control,
//                     observes EX register, stall_out and stall_count)
//            slave  - the operand stage itself
// Revision : 1.0 - initial release
// ============================================================================
interface scalar_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    // ID stage instruction fields
    logic              in_valid;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic              in_we;
    logic              in_is_load;
    // Register file read ports
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    // Forwarding sources
    logic [DATA_W-1:0] ex_result;
    logic [ADDR_W-1:0] mem_rd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_result;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_we;
    logic [DATA_W-1:0] wb_data;
    // Pipeline control
    logic              stall_in;
    logic              flush;
    logic              stall_out;
    // EX pipeline register
    logic              out_valid;
    logic [DATA_W-1:0] out_op1;
    logic [DATA_W-1:0] out_op2;
    logic [ADDR_W-1:0] out_rd;
    logic              out_we;
    logic              out_is_load;
    // Performance counter
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_we, in_is_load,
        output rf_data1, rf_data2,
        output ex_result, mem_rd, mem_we, mem_result, wb_rd, wb_we, wb_data,
        output stall_in, flush,
        input  stall_out,
        input  out_valid, out_op1, out_op2, out_rd, out_we, out_is_load,
        input  stall_count
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_we, in_is_load,
        input  rf_data1, rf_data2,
        input  ex_result, mem_rd, mem_we, mem_result, wb_rd, wb_we, wb_data,
        input  stall_in, flush,
        output stall_out,
        output out_valid, out_op1, out_op2, out_rd, out_we, out_is_load,
        output stall_count
    );
endinterface
`default_nettype wire

// File: rtl/scalar_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : scalar_operand_stage
// Purpose  : Operand stage between the scalar register file and EX. Selects
//            each source operand from EX / MEM / WB forwarding or the register
//            file, detects load-use hazards (one bubble each), and registers
//            the result into the EX pipeline register with stall and flush.
// Ports    : clk          - system clock, rising edge
//            rst          - synchronous active-high reset
//            bus (slave)  - ID fields, RF read data, forward sources,
//                           stall_in/flush in; stall_out, EX register and
//                           stall_count out
// Revision : 1.0 - initial release
// ============================================================================
module scalar_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    scalar_operand_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // ------------------------------------------------------------------
    // EX pipeline register and counter state
    // ------------------------------------------------------------------
    logic              out_valid_q,   out_valid_d;
    logic [DATA_W-1:0] out_op1_q,     out_op1_d;
    logic [DATA_W-1:0] out_op2_q,     out_op2_d;
    logic [ADDR_W-1:0] out_rd_q,      out_rd_d;
    logic              out_we_q,      out_we_d;
    logic              out_is_load_q, out_is_load_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    // ------------------------------------------------------------------
    // Per-operand forwarding (index 0 = rs1, index 1 = rs2)
    // ------------------------------------------------------------------
    logic [1:0][ADDR_W-1:0] w_rs;
    logic [1:0][DATA_W-1:0] w_rf;
    logic [1:0][DATA_W-1:0] w_fwd;
    logic [1:0]             w_ex_match;
    logic                   w_ex_fwd_ok;
    logic                   w_load_use;
    logic                   w_stall_out;

    assign w_rs = {bus.in_rs2, bus.in_rs1};
    assign w_rf = {bus.rf_data2, bus.rf_data1};

    // A load in EX has no result yet, so it must never be forwarded from
    // EX; that case is covered by the load-use bubble instead.
    assign w_ex_fwd_ok = out_valid_q & out_we_q & ~out_is_load_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_ex_match[gi] = (out_rd_q == w_rs[gi]);

            // WB must be forwarded too: the register file only commits at
            // the clock edge, so rf_data still holds the stale value.
            assign w_fwd[gi] =
                (w_ex_fwd_ok && w_ex_match[gi])         ? bus.ex_result  :
                (bus.mem_we && (bus.mem_rd == w_rs[gi])) ? bus.mem_result :
                (bus.wb_we  && (bus.wb_rd  == w_rs[gi])) ? bus.wb_data    :
                                                           w_rf[gi];
        end
    endgenerate

    // Both sources are compared regardless of whether the opcode uses them;
    // an occasional needless bubble is cheaper than decoding operand usage.
    assign w_load_use = bus.in_valid & out_valid_q & out_is_load_q & out_we_q
                      & (|w_ex_match);

    assign w_stall_out = bus.stall_in | w_load_use;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d   = out_valid_q;
        out_op1_d     = out_op1_q;
        out_op2_d     = out_op2_q;
        out_rd_d      = out_rd_q;
        out_we_d      = out_we_q;
        out_is_load_d = out_is_load_q;

        if (bus.flush) begin
            // Only validity is killed; payload fields simply hold.
            out_valid_d = 1'b0;
        end else if (bus.stall_in) begin
            // Hold everything.
        end else if (w_load_use) begin
            // Bubble: the ID instruction is re-presented next cycle and then
            // picks up the load data through the MEM forward path.
            out_valid_d = 1'b0;
            out_we_d    = 1'b0;
        end else begin
            out_valid_d   = bus.in_valid;
            out_op1_d     = w_fwd[0];
            out_op2_d     = w_fwd[1];
            out_rd_d      = bus.in_rd;
            out_we_d      = bus.in_we      & bus.in_valid;
            out_is_load_d = bus.in_is_load & bus.in_valid;
        end
    end

    // Saturating stall counter; counts through flush as well.
    always_comb begin
        stall_count_d = stall_count_q;
        if (w_stall_out && (stall_count_q != c_cnt_max)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_rd_q      <= '0;
            out_we_q      <= 1'b0;
            out_is_load_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op1_q     <= out_op1_d;
            out_op2_q     <= out_op2_d;
            out_rd_q      <= out_rd_d;
            out_we_q      <= out_we_d;
            out_is_load_q <= out_is_load_d;
            stall_count_q <= stall_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall_out   = w_stall_out;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_op1     = out_op1_q;
    assign bus.out_op2     = out_op2_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_we      = out_we_q;
    assign bus.out_is_load = out_is_load_q;
    assign bus.stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_scalar_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_scalar_operand_stage
// Purpose  : Directed self-checking bench for scalar_operand_stage. Expected
//            EX-register contents are queued when an instruction is issued and
//            compared when the stage captures a new output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scalar_operand_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              ld;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb[$];

    scalar_operand_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    scalar_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        bus.in_valid   = 1'b0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_rd      = '0;
        bus.in_we      = 1'b0;
        bus.in_is_load = 1'b0;
        bus.rf_data1   = '0;
        bus.rf_data2   = '0;
        bus.ex_result  = '0;
        bus.mem_rd     = '0;
        bus.mem_we     = 1'b0;
        bus.mem_result = '0;
        bus.wb_rd      = '0;
        bus.wb_we      = 1'b0;
        bus.wb_data    = '0;
        bus.stall_in   = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic randomize_inputs();
        bus.in_valid   = 1'($urandom);
        bus.in_rs1     = ADDR_W'($urandom);
        bus.in_rs2     = ADDR_W'($urandom);
        bus.in_rd      = ADDR_W'($urandom);
        bus.in_we      = 1'($urandom);
        bus.in_is_load = 1'($urandom);
        bus.rf_data1   = $urandom;
        bus.rf_data2   = $urandom;
        bus.ex_result  = $urandom;
        bus.mem_rd     = ADDR_W'($urandom);
        bus.mem_we     = 1'($urandom);
        bus.mem_result = $urandom;
        bus.wb_rd      = ADDR_W'($urandom);
        bus.wb_we      = 1'($urandom);
        bus.wb_data    = $urandom;
        bus.stall_in   = 1'($urandom);
        bus.flush      = 1'($urandom);
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         input logic [ADDR_W-1:0] rd, input logic we, input logic ld,
                         input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
        bus.in_valid   = 1'b1;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_rd      = rd;
        bus.in_we      = we;
        bus.in_is_load = ld;
        bus.rf_data1   = d1;
        bus.rf_data2   = d2;
    endtask

    // Advance one clock; a new EX-register value exists when out_valid is
    // high and the previous cycle neither stalled nor reset.
    task automatic tick();
        logic held;
        exp_t e;
        held = bus.stall_in | rst;
        @(posedge clk);
        #1;
        if (!held && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 128'(bus.out_valid), 128'(1'b0));
            end else begin
                e = sb.pop_front();
                chk("out_pkt", 128'({bus.out_op1, bus.out_op2, bus.out_rd,
                                     bus.out_we, bus.out_is_load}), 128'(e));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;

        // ---------------- reset with random inputs ----------------
        randomize_inputs();
        @(posedge clk);
        randomize_inputs();
        @(posedge clk);
        #1;
        set_idle();
        #1;
        chk("rst_out_valid",   128'(bus.out_valid),   128'(0));
        chk("rst_out_op1",     128'(bus.out_op1),     128'(0));
        chk("rst_out_op2",     128'(bus.out_op2),     128'(0));
        chk("rst_out_rd",      128'(bus.out_rd),      128'(0));
        chk("rst_out_we",      128'(bus.out_we),      128'(0));
        chk("rst_out_is_load", 128'(bus.out_is_load), 128'(0));
        chk("rst_stall_count", 128'(bus.stall_count), 128'(0));
        chk("rst_stall_out",   128'(bus.stall_out),   128'(0));
        rst = 1'b0;
        tick();
        tick();
        chk("idle_out_valid", 128'(bus.out_valid), 128'(0));

        // ---------------- EX forward beats MEM ----------------
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h10, 32'h20);
        sb.push_back('{32'h10, 32'h20, 5'd3, 1'b1, 1'b0});
        tick();
        issue(5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 32'h1111_1111, 32'h44);
        bus.ex_result  = 32'h0000_00AA;
        bus.mem_we     = 1'b1;
        bus.mem_rd     = 5'd3;
        bus.mem_result = 32'h0000_00BB;
        #1;
        chk("ex_fwd_no_stall", 128'(bus.stall_out), 128'(0));
        sb.push_back('{32'h0000_00AA, 32'h44, 5'd8, 1'b1, 1'b0});
        tick();

        // ---------------- WB-only forward ----------------
        bus.mem_we = 1'b0;
        issue(5'd9, 5'd7, 5'd10, 1'b0, 1'b0, 32'h99, 32'h0);
        bus.wb_we   = 1'b1;
        bus.wb_rd   = 5'd7;
        bus.wb_data = 32'hDEAD_BEEF;
        sb.push_back('{32'h99, 32'hDEAD_BEEF, 5'd10, 1'b0, 1'b0});
        tick();
        bus.wb_we = 1'b0;
        sb.push_back('{32'h99, 32'h0, 5'd10, 1'b0, 1'b0});
        tick();

        // ---------------- register 0 forwards like any other ----------------
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h5, 32'h6);
        bus.mem_we     = 1'b1;
        bus.mem_rd     = 5'd0;
        bus.mem_result = 32'h77;
        sb.push_back('{32'h77, 32'h77, 5'd0, 1'b1, 1'b0});
        tick();

        // ---------------- load-use bubble ----------------
        bus.mem_we = 1'b0;
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'h1, 32'h2);
        sb.push_back('{32'h1, 32'h2, 5'd5, 1'b1, 1'b1});
        tick();
        chk("pre_load_use_count", 128'(bus.stall_count), 128'(0));
        issue(5'd5, 5'd6, 5'd11, 1'b1, 1'b0, 32'h0BAD, 32'h66);
        #1;
        chk("load_use_stall_out", 128'(bus.stall_out), 128'(1));
        tick();
        chk("bubble_out_valid", 128'(bus.out_valid), 128'(0));
        chk("bubble_count",     128'(bus.stall_count), 128'(1));
        bus.mem_we     = 1'b1;
        bus.mem_rd     = 5'd5;
        bus.mem_result = 32'h1234;
        #1;
        chk("replay_stall_out", 128'(bus.stall_out), 128'(0));
        sb.push_back('{32'h1234, 32'h66, 5'd11, 1'b1, 1'b0});
        tick();
        chk("one_bubble_count", 128'(bus.stall_count), 128'(1));

        // ---------------- downstream stall, then flush ----------------
        bus.mem_we   = 1'b0;
        issue(5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 32'hCC, 32'hDD);
        bus.stall_in = 1'b1;
        #1;
        chk("stall_in_stall_out", 128'(bus.stall_out), 128'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", 128'({bus.out_valid, bus.out_op1, bus.out_op2, bus.out_rd, bus.out_we}),
                128'({1'b1, 32'h1234, 32'h66, 5'd11, 1'b1}));
        end
        chk("stall_count_3", 128'(bus.stall_count), 128'(4));
        bus.flush = 1'b1;
        tick();
        chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
        chk("flush_count",     128'(bus.stall_count), 128'(5));

        // ---------------- saturation and mid-stall reset ----------------
        set_idle();
        issue(5'd20, 5'd21, 5'd22, 1'b1, 1'b0, 32'hA0, 32'hB0);
        sb.push_back('{32'hA0, 32'hB0, 5'd22, 1'b1, 1'b0});
        tick();
        set_idle();
        bus.stall_in = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        chk("sat_count",     128'(bus.stall_count), 128'(16'hFFFF));
        tick();
        chk("sat_hold",      128'(bus.stall_count), 128'(16'hFFFF));
        chk("sat_out_valid", 128'(bus.out_valid),   128'(1));
        rst = 1'b1;
        tick();
        chk("mid_rst_count",     128'(bus.stall_count), 128'(0));
        chk("mid_rst_out_valid", 128'(bus.out_valid),   128'(0));
        rst = 1'b0;
        set_idle();
        tick();
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scalar_operand_stage.md
Name: scalar_operand_stage

Overview:
- Pipeline stage directly downstream of the scalar register file. It takes the decoded instruction fields and the two combinational read ports of the register file.
- Resolves data hazards by forwarding from the EX, MEM and WB stages, and detects load-use hazards, inserting a one-cycle bubble for each.
- Registers the resolved operands into the EX-stage pipeline register. Supports downstream stall and flush.

Parameters:
- DATA_W, 32, scalar datapath width.
- ADDR_W, 5, register index width (matches register file address ports).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ID holds a valid instruction.
- in_rs1, in_rs2  in  ADDR_W  source indices, also driven to the register file read ports.
- in_rd  in  ADDR_W  destination index.
- in_we  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load.
- rf_data1, rf_data2  in  DATA_W  register file read data for rs1/rs2.
- ex_result  in  DATA_W  EX result of the instruction currently in out_* registers.
- mem_rd  in  ADDR_W;  mem_we  in  1;  mem_result  in  DATA_W  MEM-stage writer.
- wb_rd  in  ADDR_W;  wb_we  in  1;  wb_data  in  DATA_W  WB-stage writer (same data driven into the register file).
- stall_in  in  1  downstream cannot accept; hold EX register.
- flush  in  1  kill instruction being captured and EX register contents.
- stall_out  out  1  ID must hold its instruction this cycle.
- out_valid  out  1;  out_op1, out_op2  out  DATA_W;  out_rd  out  ADDR_W;  out_we  out  1;  out_is_load  out  1  EX pipeline register.
- stall_count  out  CNT_W  cycles in which stall_out was high.

Behaviour:
- Reset (rst high at clock edge): out_valid=0, out_op1=out_op2=0, out_rd=0, out_we=0, out_is_load=0, stall_count=0. stall_out is combinational and reads 0 while out_valid=0 and stall_in=0. rst overrides flush and stall_in; a mid-operation reset discards the held instruction.
- Forward select, evaluated per operand and combinationally against in_rs1/in_rs2. Priority, highest first:
  1. EX: out_valid & out_we & !out_is_load & out_rd==rs -> ex_result.
  2. MEM: mem_we & mem_rd==rs -> mem_result.
  3. WB: wb_we & wb_rd==rs -> wb_data. The register file writes only at the edge, so same-cycle WB data is not yet visible on rf_data.
  4. Otherwise rf_data.
- Comparisons use all ADDR_W bits. There is no hardwired-zero register; index 0 forwards like any other.
- Load-use hazard: hazard = in_valid & out_valid & out_is_load & out_we & (out_rd==in_rs1 | out_rd==in_rs2). The comparison applies to both sources even if the opcode ignores one.
- stall_out = stall_in | hazard.
- Next-state, by priority:
  - flush: out_valid<=0. Other fields are don't-care but must be held.
  - stall_in: all out_* hold.
  - hazard: out_valid<=0 (bubble) and out_we<=0. The ID instruction is re-presented next cycle and then takes its load value via the MEM forward.
  - else: capture in_valid, the forwarded operands, in_rd, in_we & in_valid, and in_is_load & in_valid.
- Latency: 1 cycle from ID to out_*. A load-use pair costs exactly 1 bubble.
- Invalid input (in_valid=0, no stall): out_valid<=0, out_we<=0.
- stall_count increments each cycle stall_out=1 and rst=0, and saturates at all-ones (no wrap). It keeps counting during flush.
- Flush and hazard in the same cycle: flush wins. stall_out still reflects hazard in that cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with random inputs -> all outputs 0, stall_count=0. After release with in_valid=0 -> out_valid stays 0.
- EX forward: cycle n "r3<=…" captured with out_we=1; cycle n+1 issue rs1=3, ex_result=0x0000_00AA, rf_data1=0x1111_1111, mem_we=1 mem_rd=3 mem_result=0x0000_00BB -> out_op1=0x0000_00AA (EX beats MEM).
- WB-only forward: wb_we=1 wb_rd=7 wb_data=0xDEAD_BEEF, rs2=7, rf_data2=0 -> out_op2=0xDEAD_BEEF. With wb_we=0 -> out_op2=0.
- Load-use: load to r5 in EX (out_is_load=1), ID rs1=5 -> stall_out=1 for exactly 1 cycle, out_valid=0 next cycle, stall_count=1. Next cycle mem_rd=5 mem_result=0x1234 -> out_op1=0x1234.
- Stall vs flush: stall_in=1 for 3 cycles -> out_* unchanged, stall_count+=3. Then flush=1 with stall_in=1 -> out_valid=0 next cycle.
- Saturation: preset via 65540 stall cycles -> stall_count=0xFFFF held. rst=1 mid-stall -> stall_count=0, out_valid=0.
